seq_addsub_multiplier: RTL and testbench

// Parametrised sequential add-shift multiplier built around a (WIDTH+1)-bit add/sub datapath.

---
 rtl/seq_addsub_multiplier_if.sv | 13 +
 rtl/seq_addsub_multiplier.sv | 62 ++++++
 tb/tb_seq_addsub_multiplier.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_multiplier_if.sv
// seq_addsub_multiplier_if: start/done handshake, operands and product of the sequential multiplier.
interface seq_addsub_multiplier_if #(parameter int WIDTH = 8);
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
  logic X;
  modport master(output start, signed_mode, A_in, B_in, input busy, done, product, X);
  modport slave(input start, signed_mode, A_in, B_in, output busy, done, product, X);
endinterface

// File: rtl/seq_addsub_multiplier.sv
// seq_addsub_multiplier: add-shift multiplier, one partial product per clock over a (WIDTH+1)-bit add/sub path.
module seq_addsub_multiplier #(
  parameter int WIDTH = 8
) (
  input logic Clk,
  input logic Reset_n,
  seq_addsub_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_s, r_a, r_b;
  logic r_x, r_mode;
  logic [CW-1:0] r_count;
  logic [WIDTH:0] w_ext, w_acc, w_sum;
  logic w_last, w_accept;
  assign w_last = r_count == CW'(WIDTH - 1);
  assign w_accept = r_state == IDLE && bus.start;
  assign w_ext = r_mode ? {r_s[WIDTH-1], r_s} : {1'b0, r_s};
  assign w_acc = r_mode ? {r_x, r_a} : {1'b0, r_a};
  // The signed multiplier's top bit weighs -2^(WIDTH-1), so the last step subtracts.
  assign w_sum = !r_b[0] ? w_acc
               : (w_last && r_mode) ? w_acc + ~w_ext + (WIDTH+1)'(1)
               : w_acc + w_ext;
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? RUN
           : (r_state == RUN && w_last) ? DONE
           : (r_state == DONE && !bus.start) ? IDLE
           : r_state;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s <= '0;
      r_a <= '0;
      r_b <= '0;
      r_x <= 1'b0;
      r_mode <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_s <= bus.A_in;
      r_b <= bus.B_in;
      r_mode <= bus.signed_mode;
      r_a <= '0;
      r_x <= 1'b0;
      r_count <= '0;
    end else if (r_state == RUN) begin
      r_x <= w_sum[WIDTH];
      r_a <= w_sum[WIDTH:1];
      r_b <= {w_sum[0], r_b[WIDTH-1:1]};
      if (!w_last) r_count <= r_count + CW'(1);
    end
  end
  assign bus.busy = r_state == RUN;
  assign bus.done = r_state == DONE;
  assign bus.product = {r_a, r_b};
  assign bus.X = r_x;
endmodule

// File: tb/tb_seq_addsub_multiplier.sv
// tb_seq_addsub_multiplier: directed vectors for WIDTH 8, 4 and 16 instances of the multiplier.
module tb_seq_addsub_multiplier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  seq_addsub_multiplier_if #(8) if8();
  seq_addsub_multiplier_if #(4) if4();
  seq_addsub_multiplier_if #(16) if16();
  seq_addsub_multiplier #(.WIDTH(8)) u8(.Clk(clk), .Reset_n(rst_n), .bus(if8.slave));
  seq_addsub_multiplier #(.WIDTH(4)) u4(.Clk(clk), .Reset_n(rst_n), .bus(if4.slave));
  seq_addsub_multiplier #(.WIDTH(16)) u16(.Clk(clk), .Reset_n(rst_n), .bus(if16.slave));

  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      output logic [15:0] p, output logic x, output int lat);
    if8.start = 1'b0;
    @(posedge clk); #1;
    if8.A_in = a; if8.B_in = b; if8.signed_mode = sm; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = if8.product;
    x = if8.X;
  endtask

  task automatic test_reset();
    if8.start = 1'b1; if8.A_in = 8'd3; if8.B_in = 8'd5; if8.signed_mode = 1'b0;
    #12;
    checks++;
    if ({if8.busy, if8.done, if8.product, if8.X} !== 19'd0) begin
      errors++; $display("FAIL reset8 got busy=%b done=%b product=%h X=%b want all 0", if8.busy, if8.done, if8.product, if8.X);
    end
    checks++;
    if ({if4.busy, if4.done, if4.product, if4.X} !== 11'd0) begin
      errors++; $display("FAIL reset4 got %b want 0", {if4.busy, if4.done, if4.product, if4.X});
    end
    checks++;
    if ({if16.busy, if16.done, if16.product, if16.X} !== 35'd0) begin
      errors++; $display("FAIL reset16 got %h want 0", {if16.busy, if16.done, if16.product, if16.X});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if8.busy !== 1'b1) begin
      errors++; $display("FAIL start_out_of_reset busy=%b want 1", if8.busy);
    end
    if8.start = 1'b0;
    for (int i = 0; i < 40 && !if8.done; i++) begin @(posedge clk); #1; end
    checks++;
    if (if8.done !== 1'b1 || if8.product !== 16'h000F) begin
      errors++; $display("FAIL start_out_of_reset_result done=%b product=%h want 1 000f", if8.done, if8.product);
    end
  endtask

  task automatic test_signed();
    logic [15:0] p; logic x; int lat;
    mul8(8'h07, 8'hFD, 1'b1, p, x, lat);
    checks++;
    if (p !== 16'hFFEB || x !== 1'b1) begin
      errors++; $display("FAIL signed_7x-3 product=%h X=%b want ffeb 1", p, x);
    end
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL latency got %0d edges want 8", lat);
    end
    mul8(8'h80, 8'h80, 1'b1, p, x, lat);
    checks++;
    if (p !== 16'h4000 || x !== 1'b0) begin
      errors++; $display("FAIL signed_-128x-128 product=%h X=%b want 4000 0", p, x);
    end
    mul8(8'h80, 8'h7F, 1'b1, p, x, lat);
    checks++;
    if (p !== 16'hC080) begin
      errors++; $display("FAIL signed_-128x127 product=%h want c080", p);
    end
    mul8(8'h00, 8'h00, 1'b1, p, x, lat);
    checks++;
    if (p !== 16'h0000 || lat !== 8) begin
      errors++; $display("FAIL zero_operands product=%h lat=%0d want 0000 8", p, lat);
    end
  endtask

  task automatic test_unsigned();
    logic [15:0] p; logic x; int lat;
    mul8(8'hFF, 8'hFF, 1'b0, p, x, lat);
    checks++;
    if (p !== 16'hFE01) begin
      errors++; $display("FAIL unsigned_255x255 product=%h want fe01", p);
    end
    mul8(8'hFF, 8'hFF, 1'b1, p, x, lat);
    checks++;
    if (p !== 16'h0001 || x !== 1'b0) begin
      errors++; $display("FAIL signed_-1x-1 product=%h X=%b want 0001 0", p, x);
    end
    mul8(8'h0D, 8'hB3, 1'b0, p, x, lat);
    checks++;
    if (p !== 16'h0917) begin
      errors++; $display("FAIL unsigned_13x179 product=%h want 0917", p);
    end
  endtask

  task automatic test_width4();
    int lat = 0;
    @(posedge clk); #1;
    if4.A_in = 4'h8; if4.B_in = 4'h7; if4.signed_mode = 1'b1; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    while (!if4.done && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (if4.product !== 8'hC8 || if4.X !== 1'b1 || lat !== 4) begin
      errors++; $display("FAIL w4_-8x7 product=%h X=%b lat=%0d want c8 1 4", if4.product, if4.X, lat);
    end
  endtask

  task automatic test_width16();
    int lat = 0;
    @(posedge clk); #1;
    if16.A_in = 16'hFFFF; if16.B_in = 16'h0002; if16.signed_mode = 1'b0; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    while (!if16.done && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (if16.product !== 32'h0001FFFE || lat !== 16) begin
      errors++; $display("FAIL w16_ffffx2 product=%h lat=%0d want 0001fffe 16", if16.product, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] p; logic x; int lat = 0;
    @(posedge clk); #1;
    if8.A_in = 8'd5; if8.B_in = 8'd6; if8.signed_mode = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    while (!if8.done && lat < 40) begin @(posedge clk); #1; lat++; end
    if8.A_in = 8'd99; if8.B_in = 8'd77;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (if8.done !== 1'b1 || if8.busy !== 1'b0 || if8.product !== 16'h001E) begin
        errors++; $display("FAIL hold_start cyc%0d done=%b busy=%b product=%h want 1 0 001e", i, if8.done, if8.busy, if8.product);
      end
    end
    if8.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (if8.done !== 1'b0 || if8.busy !== 1'b0 || if8.product !== 16'h001E) begin
      errors++; $display("FAIL release_idle done=%b busy=%b product=%h want 0 0 001e", if8.done, if8.busy, if8.product);
    end
    mul8(8'd9, 8'd9, 1'b0, p, x, lat);
    checks++;
    if (p !== 16'h0051) begin
      errors++; $display("FAIL repress product=%h want 0051", p);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat = 0;
    @(posedge clk); #1;
    if8.A_in = 8'h07; if8.B_in = 8'hFD; if8.signed_mode = 1'b1; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if8.busy, if8.done, if8.product, if8.X} !== 19'd0) begin
      errors++; $display("FAIL reset_mid_run busy=%b done=%b product=%h X=%b want all 0", if8.busy, if8.done, if8.product, if8.X);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    if8.A_in = 8'h80; if8.B_in = 8'h7F; if8.signed_mode = 1'b1; if8.start = 1'b1;
    @(posedge clk); #1;
    while (!if8.done && lat < 40) begin
      if8.start = ~if8.start;
      if8.A_in = 8'(lat * 37 + 1);
      if8.signed_mode = ~if8.signed_mode;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (if8.product !== 16'hC080 || lat !== 8) begin
      errors++; $display("FAIL toggle_during_run product=%h lat=%0d want c080 8", if8.product, lat);
    end
    if8.start = 1'b0;
  endtask

  initial begin
    if8.start = 1'b0; if8.A_in = '0; if8.B_in = '0; if8.signed_mode = 1'b0;
    if4.start = 1'b0; if4.A_in = '0; if4.B_in = '0; if4.signed_mode = 1'b0;
    if16.start = 1'b0; if16.A_in = '0; if16.B_in = '0; if16.signed_mode = 1'b0;
    test_reset();
    test_signed();
    test_unsigned();
    test_width4();
    test_width16();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
